// File: rtl/fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pkg
//   Shared definitions for the fetch front end (fetch_pc_unit, branch_predictor).
//   Holds the address width, default reset PC, FSM state encodings, the
//   pending-request slot layout and the wrapping sequential-PC helper.
// ---------------------------------------------------------------------------
package fetch_pc_unit_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Context captured when a request is accepted, replayed with the returned word.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_addr;
  } pend_t;

  // Sequential successor; the add truncates, so the top address wraps to 0.
  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc,
                                               input int unsigned       step);
    return pc + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
//   Purely combinational next-PC select: redirect > prediction > sequential.
//   When nothing advances the PC, the current value is passed through.
// Ports:
//   cur_pc          current fetch PC
//   advance         a fetch request is accepted this cycle
//   predict_valid   predictor hit for cur_pc
//   predict_addr    predicted target
//   redirect_valid  EXEC redirect
//   redirect_addr   redirect target
//   next_pc         PC to load on the next rising edge
// ---------------------------------------------------------------------------
module next_pc_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned PC_STEP = 1
) (
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic              advance,
  input  logic              predict_valid,
  input  logic [ADDR_W-1:0] predict_addr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    if (redirect_valid)
      next_pc = redirect_addr;
    else if (advance && predict_valid)
      next_pc = predict_addr;
    else if (advance)
      next_pc = seq_pc(cur_pc, PC_STEP);
    else
      next_pc = cur_pc;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Instruction fetch PC sequencer with a single outstanding memory request.
//   Produces the fetch-to-decode bundle and handles redirects from EXEC.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   f_predict_valid/addr               predictor result for f_pc
//   x_redirect_valid/addr              EXEC redirect (highest priority)
//   imem_ready                         memory accepts the request this cycle
//   imem_rsp_valid/data                returned instruction word
//   d_stall                            decode cannot accept
//   f_pc                               current fetch PC (predictor lookup)
//   imem_req_valid/addr                fetch request (addr == f_pc)
//   fd_valid/pc/instr/pred_taken/addr  fetch-to-decode bundle
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// FETCH | request f_pc
// WAIT  | request accepted, waiting for the word
// HOLD  | word registered, decode stalled; bundle held
// DRAIN | redirected while waiting; discard the late word
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_predict_valid,
  input  logic [ADDR_W-1:0] f_predict_addr,
  input  logic              x_redirect_valid,
  input  logic [ADDR_W-1:0] x_redirect_addr,
  input  logic              imem_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              d_stall,
  output logic [ADDR_W-1:0] f_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  output logic              fd_valid,
  output logic [ADDR_W-1:0] fd_pc,
  output logic [31:0]       fd_instr,
  output logic              fd_pred_taken,
  output logic [ADDR_W-1:0] fd_pred_addr
);

  logic [2:0]        state;
  pend_t             pend;
  logic              accept;
  logic [ADDR_W-1:0] next_pc;

  // A redirect cancels the request in the same cycle so the stale PC never issues.
  assign imem_req_valid = (state == ST_FETCH) && !x_redirect_valid;
  assign imem_req_addr  = f_pc;
  assign accept         = imem_req_valid && imem_ready;

  next_pc_mux #(
    .PC_STEP (PC_STEP)
  ) u_next_pc_mux (
    .cur_pc         (f_pc),
    .advance        (accept),
    .predict_valid  (f_predict_valid),
    .predict_addr   (f_predict_addr),
    .redirect_valid (x_redirect_valid),
    .redirect_addr  (x_redirect_addr),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      f_pc          <= RESET_PC;
      pend          <= '0;
      fd_valid      <= 1'b0;
      fd_pc         <= '0;
      fd_instr      <= '0;
      fd_pred_taken <= 1'b0;
      fd_pred_addr  <= '0;
    end else begin
      if (state != ST_IDLE)
        f_pc <= next_pc;

      fd_valid <= 1'b0;

      case (state)
        ST_IDLE: state <= ST_FETCH;

        ST_FETCH: begin
          if (accept) begin
            pend.pc         <= f_pc;
            pend.pred_taken <= f_predict_valid;
            pend.pred_addr  <= f_predict_addr;
            state           <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (x_redirect_valid) begin
            state <= imem_rsp_valid ? ST_FETCH : ST_DRAIN;
          end else if (imem_rsp_valid) begin
            fd_valid      <= 1'b1;
            fd_pc         <= pend.pc;
            fd_instr      <= imem_rsp_data;
            fd_pred_taken <= pend.pred_taken;
            fd_pred_addr  <= pend.pred_addr;
            state         <= d_stall ? ST_HOLD : ST_FETCH;
          end
        end

        ST_HOLD: begin
          if (x_redirect_valid || !d_stall)
            state <= ST_FETCH;
          else
            fd_valid <= 1'b1;
        end

        // A redirect here only moves f_pc; the outstanding word still has to be
        // swallowed, and if it lands in the same cycle nothing is left to wait for.
        ST_DRAIN: begin
          if (imem_rsp_valid)
            state <= ST_FETCH;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        f_predict_valid;
  logic [31:0] f_predict_addr;
  logic        x_redirect_valid;
  logic [31:0] x_redirect_addr;
  logic        imem_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        d_stall;
  logic [31:0] f_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        fd_valid;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_pred_taken;
  logic [31:0] fd_pred_addr;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .f_predict_valid  (f_predict_valid),
    .f_predict_addr   (f_predict_addr),
    .x_redirect_valid (x_redirect_valid),
    .x_redirect_addr  (x_redirect_addr),
    .imem_ready       (imem_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .d_stall          (d_stall),
    .f_pc             (f_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .fd_valid         (fd_valid),
    .fd_pc            (fd_pc),
    .fd_instr         (fd_instr),
    .fd_pred_taken    (fd_pred_taken),
    .fd_pred_addr     (fd_pred_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] paddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;

  // memory responder and predictor model state
  logic        mem_pend    = 1'b0;
  logic        mem_discard = 1'b0;
  logic [31:0] mem_addr    = '0;
  int          mem_cnt     = 0;
  int          lat         = 0;
  logic        mp_taken    = 1'b0;
  logic [31:0] mp_paddr    = '0;
  logic        pred_en     = 1'b0;
  logic [31:0] pred_pc     = '0;
  logic [31:0] pred_tgt    = '0;

  function automatic logic [31:0] mk_instr(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample at negedge (scoreboard pop, request capture), drive at posedge+2.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (fd_valid && !d_stall) begin
      if (exp_q.size() == 0) begin
        chk("fd_unexpected", {31'b0, fd_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk("fd_pc", fd_pc, e.pc);
        chk("fd_instr", fd_instr, e.instr);
        chk("fd_pred_taken", {31'b0, fd_pred_taken}, {31'b0, e.taken});
        chk("fd_pred_addr", fd_pred_addr, e.paddr);
      end
    end else if (fd_valid && exp_q.size() != 0) begin
      chk("hold_pc", fd_pc, exp_q[0].pc);
    end
    if (imem_req_valid && imem_ready) begin
      req_log.push_back(imem_req_addr);
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = lat;
      mp_taken = f_predict_valid;
      mp_paddr = f_predict_addr;
    end
    @(posedge clk);
    #2;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mk_instr(mem_addr);
        mem_pend       = 1'b0;
        if (mem_discard) mem_discard = 1'b0;
        else exp_q.push_back('{mem_addr, mk_instr(mem_addr), mp_taken, mp_paddr});
      end else begin
        mem_cnt--;
      end
    end
    f_predict_valid = pred_en && (f_pc == pred_pc);
    f_predict_addr  = pred_tgt;
  endtask

  // One-cycle redirect; removes whatever word the redirect is expected to kill.
  task automatic redirect(input logic [31:0] a);
    x_redirect_valid = 1'b1;
    x_redirect_addr  = a;
    if (imem_rsp_valid) void'(exp_q.pop_back());
    else if (mem_pend) mem_discard = 1'b1;
    else if (fd_valid && d_stall && exp_q.size() != 0) void'(exp_q.pop_back());
    #1 chk("redir_noreq", {31'b0, imem_req_valid}, 32'd0);
    tick();
    x_redirect_valid = 1'b0;
    chk("redir_pc", f_pc, a);
    chk("redir_fd", {31'b0, fd_valid}, 32'd0);
  endtask

  task automatic run_reqs(input int n);
    int target;
    target = req_log.size() + n;
    imem_ready = 1'b1;
    for (int i = 0; i < 200 && req_log.size() < target; i++) tick();
    imem_ready = 1'b0;
    chk("req_budget", 32'(req_log.size()), 32'(target));
  endtask

  task automatic drain();
    logic done;
    done       = 1'b0;
    imem_ready = 1'b0;
    d_stall    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!mem_pend && exp_q.size() == 0 && !imem_rsp_valid && !fd_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] p1_seq [6];
    int          seen;
    int          cnt;

    p1_seq = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h40, 32'h41};
    rst_n = 1'b0;
    f_predict_valid = 1'b0;  f_predict_addr  = '0;
    x_redirect_valid = 1'b0; x_redirect_addr = '0;
    imem_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    d_stall = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_f_pc", f_pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_fd_valid", {31'b0, fd_valid}, 32'd0);
    chk("rst_fd_pc", fd_pc, 32'h0);
    chk("rst_fd_instr", fd_instr, 32'h0);
    chk("rst_fd_taken", {31'b0, fd_pred_taken}, 32'd0);
    chk("rst_fd_paddr", fd_pred_addr, 32'h0);

    rst_n = 1'b1;
    #1 chk("idle_req", {31'b0, imem_req_valid}, 32'd0);

    // sequential fetch, then prediction hit at PC 3
    pred_en = 1'b1; pred_pc = 32'h3; pred_tgt = 32'h40; f_predict_addr = pred_tgt;
    lat = 0;
    run_reqs(6);
    pred_en = 1'b0;
    for (int i = 0; i < 6; i++) chk("p1_req_addr", req_log[i], p1_seq[i]);
    drain();
    chk("p1_pc", f_pc, 32'h42);
    chk("p1_fd_count", 32'(n_pop), 32'd6);

    // decode stall while the word for PC 5 returns
    redirect(32'h5);
    d_stall = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("p2_req", req_log[$], 32'h5);
    seen = 0;
    for (int i = 0; i < 20 && seen < 4; i++) begin
      tick();
      if (fd_valid) begin
        seen++;
        chk("hold_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("hold_fd_pc", fd_pc, 32'h5);
        if (seen == 4) d_stall = 1'b0;
      end
    end
    chk("hold_cycles", 32'(seen), 32'd4);
    tick();
    chk("hold_release_drop", {31'b0, fd_valid}, 32'd0);
    chk("p2_fd_count", 32'(n_pop), 32'd7);

    // redirect in WAIT, late response discarded via DRAIN
    lat = 2; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("p3_req", req_log[$], 32'h6);
    redirect(32'h100);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (fd_valid) cnt++; end
    chk("drain_no_fd", 32'(cnt), 32'd0);
    lat = 0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("p3_next_req", req_log[$], 32'h100);
    drain();

    // redirect coincident with the response
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("p4_req", req_log[$], 32'h101);
    redirect(32'h200);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (fd_valid) cnt++; end
    chk("coinc_no_fd", 32'(cnt), 32'd0);

    // redirect while holding a stalled word
    d_stall = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    chk("p5_in_hold", {31'b0, fd_valid}, 32'd1);
    chk("p5_hold_pc", fd_pc, 32'h200);
    redirect(32'h300);
    d_stall = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (fd_valid) cnt++; end
    chk("hold_redir_no_fd", 32'(cnt), 32'd0);

    // sequential wrap at the top address
    redirect(32'hFFFF_FFFF);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("wrap_req", req_log[$], 32'hFFFF_FFFF);
    chk("wrap_pc", f_pc, 32'h0);
    drain();

    // async reset mid-WAIT, stale response afterwards
    lat = 3; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    mem_pend = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_f_pc", f_pc, 32'h0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_fd_valid", {31'b0, fd_valid}, 32'd0);
    chk("arst_fd_pc", fd_pc, 32'h0);
    chk("arst_fd_instr", fd_instr, 32'h0);
    chk("arst_fd_taken", {31'b0, fd_pred_taken}, 32'd0);
    chk("arst_fd_paddr", fd_pred_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    #1 chk("arst_idle_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    chk("stale_fd_valid", {31'b0, fd_valid}, 32'd0);
    chk("stale_f_pc", f_pc, 32'h0);
    lat = 0;
    run_reqs(1);
    chk("post_rst_req", req_log[$], 32'h0);
    drain();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("total_fd", 32'(n_pop), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_STEP, default 1, giving the sequential PC increment; the increment is word-addressed.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 f_predict_valid  in  1  predictor hit for the current f_pc.
REQ-006 f_predict_addr  in  32  predicted target for the current f_pc.
REQ-007 x_redirect_valid  in  1  EXEC mispredict or branch resolution; redirect fetch.
REQ-008 x_redirect_addr  in  32  correct next PC.
REQ-009 imem_ready  in  1  instruction memory accepts the request this cycle.
REQ-010 imem_rsp_valid  in  1  instruction word returned.
REQ-011 imem_rsp_data  in  32  instruction word.
REQ-012 d_stall  in  1  decode cannot accept an instruction.
REQ-013 f_pc  out  32  current fetch PC; also drives predictor lookup.
REQ-014 imem_req_valid  out  1  fetch request.
REQ-015 imem_req_addr  out  32  request address; SHALL equal f_pc.
REQ-016 fd_valid, fd_pc[31:0], fd_instr[31:0], fd_pred_taken, fd_pred_addr[31:0]  out  fetch-to-decode bundle.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, WAIT, HOLD and DRAIN; exactly one request SHALL be outstanding at most.
REQ-018 IDLE SHALL last one cycle after reset release, then move to FETCH; imem_req_valid SHALL be 0 in IDLE.
REQ-019 In FETCH, imem_req_valid SHALL be 1 unless x_redirect_valid=1.
REQ-020 A request SHALL be accepted when imem_req_valid=1 and imem_ready=1.
REQ-021 On acceptance, the block SHALL latch f_pc, f_predict_valid and f_predict_addr into the pending slot and move to WAIT.
REQ-022 On acceptance, f_pc SHALL become f_predict_addr if f_predict_valid=1, else f_pc+PC_STEP, with 32-bit wrap (32'hFFFF_FFFF+1 -> 0).
REQ-023 In WAIT with imem_rsp_valid=1 and d_stall=0, the next cycle SHALL present fd_valid=1 with the pending fields, and the FSM SHALL move to FETCH.
REQ-024 In WAIT with imem_rsp_valid=1 and d_stall=1, the FSM SHALL move to HOLD with the bundle registered and fd_valid=1.
REQ-025 In HOLD, the fd_* outputs SHALL remain stable until d_stall=0, then the FSM SHALL move to FETCH and fd_valid SHALL drop the following cycle unless a new word arrives.
REQ-026 fd_valid SHALL be a single-cycle pulse per instruction when d_stall=0; no instruction SHALL be duplicated or lost.
REQ-027 x_redirect_valid SHALL have highest priority: f_pc SHALL become x_redirect_addr the next cycle in every state except IDLE.
REQ-028 Redirect in FETCH SHALL keep the FSM in FETCH with no request issued that cycle.
REQ-029 Redirect in WAIT with no same-cycle response SHALL move the FSM to DRAIN; the later response SHALL be discarded and the FSM SHALL then move to FETCH.
REQ-030 Redirect in WAIT with imem_rsp_valid=1 in the same cycle SHALL discard the word and move the FSM to FETCH.
REQ-031 Redirect in HOLD SHALL drop the held word (fd_valid=0 next cycle) and move the FSM to FETCH.
REQ-032 Redirect in DRAIN SHALL update f_pc and keep the FSM in DRAIN.
REQ-033 fd_valid SHALL be 0 in any cycle following a redirect.

Reset
REQ-034 Asserting rst_n=0 SHALL immediately force: state IDLE, f_pc=RESET_PC, imem_req_valid=0, fd_valid=0, fd_pc/fd_instr/fd_pred_addr=0, fd_pred_taken=0, pending slot cleared.
REQ-035 Reset mid-request SHALL abandon the outstanding request; a response arriving in IDLE SHALL be ignored.

Structure
REQ-036 FSM state encodings, the 32-bit address width and the default RESET_PC SHALL live in a shared package used by branch_predictor and fetch_pc_unit.
REQ-037 The next-PC selection (redirect > prediction > sequential) SHALL be one sub-module, next_pc_mux, which is purely combinational.

Verification
REQ-038 Reset release, imem_ready=1, single-cycle response, no prediction -> f_pc sequence 0,1,2,3; fd_pc 0,1,2 on consecutive fd_valid pulses.
REQ-039 f_predict_valid=1 with addr=0x40 at f_pc=3 -> next f_pc=0x40; fd for PC 3 carries fd_pred_taken=1, fd_pred_addr=0x40.
REQ-040 d_stall=1 for 3 cycles while a word for PC 5 returns -> fd_pc=5 with fd_valid held 3 cycles, then one further cycle, exactly once, with no request issued during HOLD.
REQ-041 x_redirect_valid with addr=0x100 in WAIT, response 2 cycles later -> response discarded, fd_valid=0, next request addr=0x100.
REQ-042 Redirect coincident with imem_rsp_valid -> no fd_valid; redirect in HOLD -> held word dropped; f_pc=32'hFFFF_FFFF sequential -> next 0.
REQ-043 rst_n low mid-WAIT -> all outputs at reset values asynchronously; a stale response after release -> ignored.
